// File: rtl/conv_ctrl.sv
// conv_ctrl: raster-scan frame controller feeding a KxK convolution engine and writing valid-window results.
// Optional build macro CONV_CTRL_RELU_EN clamps negative results to zero on the write port.
module conv_ctrl #(
    parameter int IMG_WIDTH  = 5,
    parameter int IMG_HEIGHT = 5,
    parameter int K          = 3,
    parameter int ENG_LAT    = 2
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        start,
    input  logic                                                        abort,
    output logic                                                        busy,
    output logic                                                        done,
    output logic                                                        mem_rd_en,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]                     mem_addr,
    input  logic [7:0]                                                  mem_rd_data,
    output logic                                                        eng_clr,
    output logic [7:0]                                                  eng_pix,
    output logic                                                        eng_pix_valid,
    input  logic signed [31:0]                                          eng_result,
    output logic                                                        wr_en,
    output logic [$clog2((IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1))-1:0]         wr_addr,
    output logic signed [31:0]                                          wr_data
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int NOUT = (IMG_WIDTH - K + 1) * (IMG_HEIGHT - K + 1);
    localparam int AW   = $clog2(NPIX);
    localparam int OW   = $clog2(NOUT);
    localparam int CW   = $clog2(IMG_WIDTH + 1);
    localparam int RW   = $clog2(IMG_HEIGHT + 1);

    localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);
    localparam logic [OW-1:0] WR_LAST   = OW'(NOUT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [OW-1:0]        wa_q, wa_d;
    logic                 pv_q, win_q;
    logic [ENG_LAT-1:0]   pv_pipe_q, win_pipe_q;
    logic                 flush, win_now, inflight;
    logic signed [31:0]   res;

    assign busy          = (state_q == CLEAR) || (state_q == FETCH) || (state_q == DRAIN);
    assign done          = state_q == DONE;
    assign eng_clr       = state_q == CLEAR;
    assign mem_rd_en     = state_q == FETCH;
    assign mem_addr      = addr_q;
    assign eng_pix_valid = pv_q;
    assign eng_pix       = pv_q ? mem_rd_data : 8'd0;
    assign flush         = busy && abort;
    assign win_now       = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    assign inflight      = pv_q || (|pv_pipe_q);
    assign wr_en         = pv_pipe_q[ENG_LAT-1] && win_pipe_q[ENG_LAT-1];
    assign wr_addr       = wa_q;
`ifdef CONV_CTRL_RELU_EN
    assign res           = (eng_result < 0) ? 32'sd0 : eng_result;
`else
    assign res           = eng_result;
`endif
    assign wr_data       = wr_en ? res : 32'sd0;

    // Next-state and counter update: raster address with row/col tag, result address per write.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        wa_d    = wa_q;
        case (state_q)
            IDLE:  if (start && !abort) state_d = CLEAR;
            CLEAR: begin
                state_d = FETCH;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
                wa_d    = '0;
            end
            FETCH: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    col_d  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    row_d  = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
                end
            end
            DRAIN: if (!inflight) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wr_en && wa_q != WR_LAST) wa_d = wa_q + 1'b1;
        if (flush) state_d = IDLE;
    end

    // FSM state and scan counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wa_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wa_q    <= wa_d;
        end
    end

    // Tag pipeline: pixel-valid stage then ENG_LAT stages aligned with the engine result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q       <= 1'b0;
            win_q      <= 1'b0;
            pv_pipe_q  <= '0;
            win_pipe_q <= '0;
        end else if (flush) begin
            pv_q       <= 1'b0;
            win_q      <= 1'b0;
            pv_pipe_q  <= '0;
            win_pipe_q <= '0;
        end else begin
            pv_q          <= mem_rd_en;
            win_q         <= mem_rd_en && win_now;
            pv_pipe_q[0]  <= pv_q;
            win_pipe_q[0] <= win_q;
            for (int i = 1; i < ENG_LAT; i++) begin
                pv_pipe_q[i]  <= pv_pipe_q[i-1];
                win_pipe_q[i] <= win_pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: scoreboard bench for conv_ctrl with a 5x5 ramp image and a 2-cycle echo engine.
module tb_conv_ctrl;

    localparam int W = 5;
    localparam int H = 5;
`ifdef CONV_CTRL_RELU_EN
    localparam int NEG_EXP = 0;
`else
    localparam int NEG_EXP = -5;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done, mem_rd_en, eng_clr, eng_pix_valid, wr_en;
    logic [4:0]         mem_addr;
    logic [7:0]         mem_rd_data = 8'd0;
    logic [7:0]         eng_pix;
    logic signed [31:0] eng_result, wr_data;
    logic [3:0]         wr_addr;
    logic [7:0]         e1 = 8'd0, e2 = 8'd0;
    logic               neg_mode = 1'b0;
    logic               prev_clr = 1'b0;

    int errors = 0, checks = 0;
    int done_cnt = 0, wr_cnt = 0, clr_cnt = 0, exp_ma = 0;
    int q_addr[$], q_data[$];

    conv_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .K(3), .ENG_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .eng_clr(eng_clr), .eng_pix(eng_pix), .eng_pix_valid(eng_pix_valid),
        .eng_result(eng_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'(mem_addr);

    always @(posedge clk) begin
        e1 <= eng_pix_valid ? eng_pix : 8'd0;
        e2 <= e1;
    end
    assign eng_result = neg_mode ? -32'sd5 : 32'(e2);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_windows(input int count, input logic neg);
        int n = 0;
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                if (n < count) begin
                    q_addr.push_back(n);
                    q_data.push_back(neg ? NEG_EXP : r * W + c);
                    n++;
                end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, int'(done), 1);
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (q_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write", wr_addr, wr_data);
            end else begin
                check("wr_addr", int'(wr_addr), q_addr.pop_front());
                check("wr_data", wr_data, q_data.pop_front());
            end
        end
        if (eng_clr) begin
            clr_cnt++;
            exp_ma = 0;
        end
        if (mem_rd_en) begin
            if (exp_ma == 0) check("clr_before_rd", int'(prev_clr), 1);
            check("mem_addr", int'(mem_addr), exp_ma);
            exp_ma++;
        end
        if (done) begin
            done_cnt++;
            check("reads_per_pass", exp_ma, W * H);
        end
        prev_clr = eng_clr;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n, c0;
        #12;
        check("rst_strobes", int'({busy, done, mem_rd_en, eng_clr, eng_pix_valid, wr_en}), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_eng_pix", int'(eng_pix), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        push_windows(9, 1'b0);
        pulse_start();
        check("clear_cycle_clr", int'(eng_clr), 1);
        check("clear_cycle_busy", int'(busy), 1);
        @(negedge clk);
        check("clr_one_cycle", int'(eng_clr), 0);
        check("fetch_after_clear", int'(mem_rd_en), 1);
        wait_done("pass1");
        check("done_busy_low", int'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_done_ignored", clr_cnt, 1);
        check("pass1_done_cnt", done_cnt, 1);
        check("pass1_wr_cnt", wr_cnt, 9);
        check("pass1_queue_empty", q_addr.size(), 0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("abort_start_idle_clr", clr_cnt, 1);

        pulse_start();
        n = 0;
        while (!(mem_rd_en && mem_addr == 5'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_point_reached", int'(mem_rd_en && mem_addr == 5'd10), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_strobes", int'({mem_rd_en, eng_pix_valid, wr_en, done}), 0);
        repeat (40) @(negedge clk);
        check("abort_no_writes", wr_cnt, 9);
        check("abort_no_done", done_cnt, 1);
        push_windows(9, 1'b0);
        pulse_start();
        wait_done("pass2");
        repeat (2) @(negedge clk);
        check("pass2_done_cnt", done_cnt, 2);
        check("pass2_wr_cnt", wr_cnt, 18);
        check("pass2_queue_empty", q_addr.size(), 0);

        push_windows(7, 1'b0);
        pulse_start();
        n = 0;
        while (!(busy && !mem_rd_en && !eng_clr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_reached", int'(busy && !mem_rd_en && !eng_clr), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_strobes", int'({busy, done, mem_rd_en, eng_clr, eng_pix_valid, wr_en}), 0);
        check("midrst_mem_addr", int'(mem_addr), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_eng_pix", int'(eng_pix), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_idle", int'(busy), 0);
        check("midrst_no_done", done_cnt, 2);
        check("midrst_wr_cnt", wr_cnt, 25);
        check("midrst_queue_empty", q_addr.size(), 0);
        push_windows(9, 1'b0);
        pulse_start();
        wait_done("pass3");
        repeat (2) @(negedge clk);
        check("pass3_done_cnt", done_cnt, 3);
        check("pass3_wr_cnt", wr_cnt, 34);
        check("pass3_queue_empty", q_addr.size(), 0);

        c0 = clr_cnt;
        push_windows(9, 1'b0);
        start = 1'b1;
        wait_done("held");
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("held_one_pass", clr_cnt - c0, 1);
        check("held_one_done", done_cnt, 4);
        check("held_queue_empty", q_addr.size(), 0);

        neg_mode = 1'b1;
        push_windows(9, 1'b1);
        pulse_start();
        wait_done("neg");
        repeat (2) @(negedge clk);
        neg_mode = 1'b0;
        check("neg_wr_cnt", wr_cnt, 52);
        check("neg_queue_empty", q_addr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
